keypad_emu: RTL and testbench
=============================

KEYPAD_EMU -- requirements
Module: keypad_emu

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000000, clocks a key is held pressed (20 ms at 50 MHz).
REQ-002 Parameter GAP_CYCLES, default 500000, clocks of release between consecutive keys.
REQ-003 Parameter DEPTH, default 4, key queue depth in entries; power of two, minimum 2.
REQ-004 Port clk  in  1  system clock; all logic on the rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port col  in  3  column scan lines from the keypad scanner; active-high.
REQ-007 Port row  out  4  emulated row return lines; active-high when a pressed key sits in an active column.
REQ-008 Port push  in  1  enqueue request for key_in; one-cycle strobe.
REQ-009 Port key_in  in  4  key code 0..11, encoded as row*3+col.
REQ-010 Port abort  in  1  flush the queue and release any key.
REQ-011 Port full  out  1  queue holds DEPTH entries.
REQ-012 Port busy  out  1  FSM is not IDLE or the queue is not empty.
REQ-013 Port done  out  1  one-cycle pulse when a key's gap period completes.
REQ-014 Port err  out  1  one-cycle pulse on a rejected push (key_in>11 or queue full).

Function
REQ-015 The queue is a FIFO of DEPTH 4-bit entries, with pointers one bit wider than the address for full/empty detection.
REQ-016 A push with key_in<=11 and !full is written to the queue in that cycle.
REQ-017 A push with key_in>11 or full is dropped, the queue is unchanged, and err is asserted on the next cycle.
REQ-018 A push and a pop in the same cycle both take effect; when full, the pop frees the slot first, so the push is accepted.
REQ-019 FSM states are IDLE, LOAD, PRESS, GAP.
REQ-020 IDLE -> LOAD when the queue is non-empty; LOAD pops the head into cur_key and clears the counter.
REQ-021 LOAD -> PRESS on the next cycle.
REQ-022 In PRESS the counter increments each cycle; PRESS -> GAP when the counter = HOLD_CYCLES-1, and the counter clears.
REQ-023 In GAP the counter increments; GAP -> IDLE when the counter = GAP_CYCLES-1, with done asserted for that one transition cycle.
REQ-024 Back-to-back keys: when the queue is non-empty at GAP exit, IDLE lasts exactly one cycle before LOAD.
REQ-025 Row is registered and updated every cycle: row[r] <= (state==PRESS) && (cur_key/3==r) && col[cur_key%3]; all other bits are 0.
REQ-026 Row-to-col latency is one clock; a multi-hot col asserts row whenever the target column bit is set.
REQ-027 Abort has priority over all other inputs: pointers clear, FSM -> IDLE, counter clears, row=0 on the next cycle, and done is not pulsed.
REQ-028 A push in the same cycle as abort is discarded without err.
REQ-029 The counter width is clog2(max(HOLD_CYCLES,GAP_CYCLES)); the counter never wraps.

Reset
REQ-030 When rst_n=0 at a clock edge: row=0, full=0, busy=0, done=0, err=0, state=IDLE, pointers=0, counter=0, cur_key=0.
REQ-031 Reset asserted mid-press releases row on the first edge with rst_n=0.
REQ-032 Queue contents are not reset; only the pointers are.

Structure
REQ-033 A shared package holds the FSM state enum, KEY_MAX=11, NUM_ROWS=4 and NUM_COLS=3.
REQ-034 The queue is a sub-module keypad_fifo with parameterised DEPTH and width, exposing push, pop, dout, full and empty.

Verification
REQ-035 Push key 5 with HOLD=4, GAP=3 and col cycling 001/010/100 -> row=0010 exactly in the cycles after col=100 during PRESS; done pulses 9 cycles after push.
REQ-036 Push 1,2,3,4,5 back-to-back with DEPTH=4 -> the first four are accepted, full=1, the fifth gives an err pulse, and the keys emerge in order 1,2,3,4.
REQ-037 Push key 12 -> err pulse, busy stays 0, row stays 0000.
REQ-038 Abort in the second PRESS cycle of key 0 with col=001 -> row=0000 on the next cycle, busy=0, no done pulse.
REQ-039 Assert rst_n=0 during GAP with two keys queued -> all outputs 0, busy=0; a subsequent push of key 7 plays normally.
REQ-040 Full queue with push and pop in the same cycle -> push accepted, no err, full stays 1.

Source files
------------

// File: rtl/keypad_emu_pkg.sv
// Shared types and constants for the keypad emulator: FSM states, keypad geometry,
// and the key-code to row/column mapping (key = row*3 + col).
package keypad_emu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PRESS = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int KEY_MAX  = 11;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int KEY_W    = 4;

    function automatic logic [1:0] key_row(input logic [KEY_W-1:0] k);
        return 2'(k / 4'd3);
    endfunction

    function automatic logic [1:0] key_col(input logic [KEY_W-1:0] k);
        return 2'(k % 4'd3);
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small FIFO for queued key codes. Pointers carry one extra wrap bit so that
// full and empty are distinguishable; storage itself is never reset.
module keypad_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // The caller only pushes when there is room (or a pop frees the head slot).
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/keypad_emu.sv
// Keypad emulator: plays queued key codes onto the row return lines of a
// column-scanned 4x3 keypad, holding each key for HOLD_CYCLES then releasing for GAP_CYCLES.
//
// state | meaning
// IDLE  | no key active; leaves for LOAD as soon as the queue is non-empty
// LOAD  | pop queue head into cur_key, clear counter
// PRESS | key held; row follows the key's column line
// GAP   | key released; done pulses on exit
module keypad_emu
    import keypad_emu_pkg::*;
#(
    parameter int HOLD_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int DEPTH       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_COLS-1:0] col,
    output logic [NUM_ROWS-1:0] row,
    input  logic                push,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                abort,
    output logic                full,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [KEY_W-1:0]    cur_key;
    logic [KEY_W-1:0]    fifo_dout;
    logic                fifo_empty;
    logic                key_ok;
    logic                pop_ok;
    logic                push_ok;
    logic [NUM_ROWS-1:0] row_next;

    assign key_ok  = (key_in <= KEY_W'(KEY_MAX));
    assign pop_ok  = (state == LOAD) && !abort;
    // A pop in the same cycle frees the head slot, so a full queue can still accept.
    assign push_ok = push && !abort && key_ok && (!full || pop_ok);

    keypad_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (key_in),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty)
    );

    always_comb begin
        row_next = '0;
        if (state == PRESS && col[key_col(cur_key)]) begin
            row_next[key_row(cur_key)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_key <= '0;
            row     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            cnt   <= '0;
            row   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            row  <= row_next;
            done <= 1'b0;
            err  <= push && !push_ok;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    cur_key <= fifo_dout;
                    cnt     <= '0;
                    state   <= PRESS;
                end
                PRESS: begin
                    if (cnt == HOLD_TC) begin
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_TC) begin
                        cnt   <= '0;
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_keypad_emu.sv
// Self-checking bench for keypad_emu: directed scenarios plus random traffic,
// compared each cycle against a phase-based reference model of the key player.
module tb_keypad_emu;
    localparam int HOLD  = 4;
    localparam int GAP   = 3;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] col;
    logic [3:0] row;
    logic       push;
    logic [3:0] key_in;
    logic       abort;
    logic       full, busy, done, err;

    always #5 clk = ~clk;

    keypad_emu #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .DEPTH       (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .col    (col),
        .row    (row),
        .push   (push),
        .key_in (key_in),
        .abort  (abort),
        .full   (full),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: p = -1 idle, 0 loading, 1..HOLD pressed, HOLD+1..HOLD+GAP released.
    int         p = -1;
    int         mq[$];
    int         cur = 0;
    logic [3:0] exp_row = '0;
    logic       exp_full = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;

    task automatic model_step();
        int size_pre;
        bit popped;
        bit room;
        if (!rst_n) begin
            mq.delete(); p = -1; cur = 0;
            exp_row = '0; exp_done = 1'b0; exp_err = 1'b0;
        end else if (abort) begin
            mq.delete(); p = -1;
            exp_row = '0; exp_done = 1'b0; exp_err = 1'b0;
        end else begin
            size_pre = mq.size();
            exp_row  = '0;
            if (p >= 1 && p <= HOLD && col[cur % 3]) exp_row[cur / 3] = 1'b1;
            exp_done = (p == HOLD + GAP);
            popped   = (p == 0);
            room     = (size_pre - (popped ? 1 : 0)) < DEPTH;
            if (popped) cur = mq.pop_front();
            exp_err = push && !(key_in <= 11 && room);
            if (push && key_in <= 11 && room) mq.push_back(int'(key_in));
            if (p == -1)              p = (size_pre > 0) ? 0 : -1;
            else if (p == HOLD + GAP) p = -1;
            else                      p++;
        end
        exp_full = (mq.size() == DEPTH);
        exp_busy = (p != -1) || (mq.size() != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        push = 1'b0; abort = 1'b0; key_in = '0; col = '0;
    endtask

    task automatic clear_with_abort();
        idle_inputs(); abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs(); rst_n = 1'b0;
        repeat (3) tick();
        total++; if (row !== 4'b0000) begin bad++; $display("FAIL reset_row got=%b want=0000", row); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int done_at = -1;
        clear_with_abort();
        for (int n = 0; n < 14; n++) begin
            push = (n == 0); key_in = 4'd5; col = 3'b001 << (n % 3);
            tick();
            if (done === 1'b1 && done_at < 0) done_at = n;
            total++; if (row !== exp_row) begin bad++; $display("FAIL single_row n=%0d got=%b want=%b", n, row, exp_row); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL single_busy n=%0d got=%b want=%b", n, busy, exp_busy); end
            total++; if (done !== exp_done) begin bad++; $display("FAIL single_done n=%0d got=%b want=%b", n, done, exp_done); end
        end
        total++; if (done_at !== 9) begin bad++; $display("FAIL single_done_latency got=%0d want=9", done_at); end
        idle_inputs();
    endtask

    task automatic test_overflow();
        int guard = 0;
        clear_with_abort();
        push = 1'b1; key_in = 4'd0;
        tick();
        push = 1'b0;
        while (p != 1 && guard < 20) begin tick(); guard++; end
        total++; if (guard >= 20) begin bad++; $display("FAIL overflow_wait got=timeout want=press"); end
        for (int k = 1; k <= 5; k++) begin
            push = 1'b1; key_in = 4'(k); col = 3'($urandom_range(0, 7));
            tick();
            total++; if (err !== exp_err) begin bad++; $display("FAIL overflow_err k=%0d got=%b want=%b", k, err, exp_err); end
            total++; if (full !== exp_full) begin bad++; $display("FAIL overflow_full k=%0d got=%b want=%b", k, full, exp_full); end
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL overflow_fifth_err got=%b want=1", err); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL overflow_full_final got=%b want=1", full); end
        push = 1'b0;
        for (int n = 0; n < 50; n++) begin
            col = 3'($urandom_range(0, 7));
            tick();
            total++; if (row !== exp_row) begin bad++; $display("FAIL overflow_row n=%0d got=%b want=%b", n, row, exp_row); end
            total++; if (done !== exp_done) begin bad++; $display("FAIL overflow_done n=%0d got=%b want=%b", n, done, exp_done); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL overflow_busy n=%0d got=%b want=%b", n, busy, exp_busy); end
        end
        idle_inputs();
    endtask

    task automatic test_bad_key();
        clear_with_abort();
        push = 1'b1; key_in = 4'd12; col = 3'b111;
        tick();
        push = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL badkey_err got=%b want=1", err); end
        for (int n = 0; n < 6; n++) begin
            tick();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL badkey_busy n=%0d got=%b want=0", n, busy); end
            total++; if (row !== 4'b0000) begin bad++; $display("FAIL badkey_row n=%0d got=%b want=0000", n, row); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL badkey_err_after n=%0d got=%b want=%b", n, err, exp_err); end
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        int guard = 0;
        int dones = 0;
        clear_with_abort();
        push = 1'b1; key_in = 4'd0; col = 3'b001;
        tick();
        push = 1'b0;
        while (p != 2 && guard < 20) begin tick(); guard++; end
        total++; if (guard >= 20) begin bad++; $display("FAIL abort_wait got=timeout want=press"); end
        total++; if (row !== 4'b0001) begin bad++; $display("FAIL abort_row_before got=%b want=0001", row); end
        abort = 1'b1; push = 1'b1; key_in = 4'd3;
        tick();
        abort = 1'b0; push = 1'b0;
        total++; if (row !== 4'b0000) begin bad++; $display("FAIL abort_row got=%b want=0000", row); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL abort_err got=%b want=0", err); end
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        idle_inputs();
    endtask

    task automatic test_full_pushpop();
        int guard = 0;
        clear_with_abort();
        while (mq.size() < DEPTH && guard < 12) begin
            push = 1'b1; key_in = 4'($urandom_range(0, 11));
            tick(); guard++;
        end
        push = 1'b0;
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fullpp_fill got=%b want=1", full); end
        guard = 0;
        while (!(p == 0 && mq.size() == DEPTH) && guard < 30) begin tick(); guard++; end
        total++; if (guard >= 30) begin bad++; $display("FAIL fullpp_wait got=timeout want=load"); end
        push = 1'b1; key_in = 4'd9;
        tick();
        push = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL fullpp_err got=%b want=0", err); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fullpp_full got=%b want=1", full); end
        total++; if (full !== exp_full) begin bad++; $display("FAIL fullpp_model got=%b want=%b", full, exp_full); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        clear_with_abort();
        for (int k = 0; k < 3; k++) begin
            push = 1'b1; key_in = 4'(3 + 2 * k);
            tick();
        end
        push = 1'b0;
        while (p <= HOLD && guard < 20) begin tick(); guard++; end
        total++; if (guard >= 20 || mq.size() != 2) begin bad++; $display("FAIL rstmid_setup got=%0d queued want=2", mq.size()); end
        rst_n = 1'b0;
        tick();
        total++; if ({row, full, busy, done, err} !== 8'h00) begin bad++; $display("FAIL rstmid_outputs got=%b want=00000000", {row, full, busy, done, err}); end
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        push = 1'b1; key_in = 4'd7;
        for (int n = 0; n < 14; n++) begin
            col = 3'($urandom_range(0, 7));
            tick();
            push = 1'b0;
            total++; if (row !== exp_row) begin bad++; $display("FAIL rstmid_row n=%0d got=%b want=%b", n, row, exp_row); end
            total++; if (done !== exp_done) begin bad++; $display("FAIL rstmid_done n=%0d got=%b want=%b", n, done, exp_done); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rstmid_busy2 n=%0d got=%b want=%b", n, busy, exp_busy); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            abort  = ($urandom_range(0, 49) == 0);
            push   = ($urandom_range(0, 2) == 0);
            key_in = 4'($urandom_range(0, 13));
            col    = 3'($urandom_range(0, 7));
            tick();
            total++; if (row !== exp_row) begin bad++; $display("FAIL rand_row n=%0d got=%b want=%b", n, row, exp_row); end
            total++; if (full !== exp_full) begin bad++; $display("FAIL rand_full n=%0d got=%b want=%b", n, full, exp_full); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rand_busy n=%0d got=%b want=%b", n, busy, exp_busy); end
            total++; if (done !== exp_done) begin bad++; $display("FAIL rand_done n=%0d got=%b want=%b", n, done, exp_done); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL rand_err n=%0d got=%b want=%b", n, err, exp_err); end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_overflow();
        test_bad_key();
        test_abort();
        test_full_pushpop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
